// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, entry type and FSM state encoding for the
// instruction fetch stage.
//   INSTR_W / ADDR_W  : instruction and word-address widths (16 bits each)
//   HLT_OPCODE_DEF    : default instr[15:12] opcode that stops fetching
//   fetch_entry_t     : {pc, instr} pair held in the prefetch queue
//   fetch_state_t     : RUN / HALTED
package fetch_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;
    localparam logic [3:0] HLT_OPCODE_DEF = 4'hF;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // True when the instruction's major opcode field equals op.
    function automatic logic opcode_is(input logic [INSTR_W-1:0] instr,
                                       input logic [3:0]         op);
        return (instr[15:12] == op);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch queue of fetch_entry_t.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_push/i_push_data : enqueue one entry
//   i_pop           : dequeue the head entry (ignored when empty)
//   i_flush         : drop every entry; wins over push and pop
//   o_count         : number of valid entries (0..DEPTH)
//   o_head          : head entry, combinational from the read pointer,
//                     all-zero when the queue is empty
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  fetch_entry_t     i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_count,
    output fetch_entry_t     o_head
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    fetch_entry_t     r_mem [DEPTH];

    logic w_not_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_not_empty = (r_count != {CNT_W{1'b0}});
    assign w_do_pop    = i_pop & w_not_empty;
    // A full queue can still accept a push when the head leaves the same cycle.
    assign w_do_push   = i_push & ((r_count != CNT_W'(DEPTH)) | w_do_pop);

    // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (i_flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are only observed through a valid read pointer.
    always_ff @(posedge clk) begin
        if (w_do_push & ~i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Head view; forced to zero when empty so decode never sees stale data.
    always_comb begin
        o_head = '0;
        if (w_not_empty) begin
            o_head = r_mem[r_rd_ptr];
        end else begin
            o_head = '0;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage (upstream of IF/ID).
// Owns the PC, issues reads to a 1-cycle-latency synchronous instruction
// memory, buffers {pc, instr} in a prefetch queue and presents the head to
// decode over valid/ready. Handles EX/MEM redirects and stops at HLT.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   im_rd_en, im_addr          : instruction memory read strobe / word address
//   im_instr                   : read data, valid the cycle after im_rd_en
//   redirect, redirect_pc      : flush and reload PC (highest priority)
//   id_valid, id_ready         : decode handshake
//   id_instr, id_pc            : head instruction and its PC (0 when empty)
//   halted                     : fetch stopped after a HLT was queued
//   perf_bubble_cnt, perf_flush_cnt : saturating counters, present only
//                                when FETCH_PERF_EN is defined
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]        HLT_OPCODE = HLT_OPCODE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               im_rd_en,
    output logic [ADDR_W-1:0]  im_addr,
    input  logic [INSTR_W-1:0] im_instr,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic               halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_bubble_cnt,
    output logic [15:0]        perf_flush_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_tag_pc;
    logic              r_inflight;
    fetch_state_t      r_state;

    logic [CNT_W-1:0]  w_count;
    fetch_entry_t      w_head;
    fetch_entry_t      w_push_data;
    logic              w_run;
    logic              w_hlt_resp;
    logic              w_credit;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;

    assign w_run      = (r_state == RUN);
    // The returning word is a HLT: hold off the next address so nothing past it is issued.
    assign w_hlt_resp = r_inflight & opcode_is(im_instr, HLT_OPCODE);
    // Queued entries plus the outstanding read may never exceed the queue size.
    assign w_credit   = (({1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight}) < (CNT_W + 1)'(DEPTH));
    // rst_n is folded in so the strobe reads 0 while reset is held.
    assign w_issue    = rst_n & w_run & ~redirect & ~w_hlt_resp & w_credit;
    assign w_push     = r_inflight & ~redirect & w_run;
    assign w_valid    = (w_count != {CNT_W{1'b0}}) & ~redirect;
    assign w_pop      = w_valid & id_ready;

    assign w_push_data.pc    = r_tag_pc;
    assign w_push_data.instr = im_instr;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (redirect),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    // PC, outstanding-read tracking and RUN/HALTED state; redirect overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_tag_pc   <= {ADDR_W{1'b0}};
            r_inflight <= 1'b0;
            r_state    <= RUN;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_inflight <= 1'b0;
            r_state    <= RUN;
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 16'd1;
                r_tag_pc   <= r_fetch_pc;
            end
            r_inflight <= w_issue;
            case (r_state)
                RUN: begin
                    if (w_push & opcode_is(im_instr, HLT_OPCODE)) begin
                        r_state <= HALTED;
                    end
                end
                HALTED:  r_state <= HALTED;
                default: r_state <= RUN;
            endcase
        end
    end

    assign im_rd_en = w_issue;
    assign im_addr  = r_fetch_pc;
    assign id_valid = w_valid;
    assign id_instr = w_head.instr;
    assign id_pc    = w_head.pc;
    assign halted   = (r_state == HALTED);

`ifdef FETCH_PERF_EN
    logic [15:0] r_perf_bubble;
    logic [15:0] r_perf_flush;

    // Saturating event counters: decode starved while running, and redirect flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_bubble <= 16'h0000;
            r_perf_flush  <= 16'h0000;
        end else begin
            if (id_ready & ~w_valid & w_run & (r_perf_bubble != 16'hFFFF)) begin
                r_perf_bubble <= r_perf_bubble + 16'd1;
            end
            if (redirect & (r_perf_flush != 16'hFFFF)) begin
                r_perf_flush <= r_perf_flush + 16'd1;
            end
        end
    end

    assign perf_bubble_cnt = r_perf_bubble;
    assign perf_flush_cnt  = r_perf_flush;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. Directed scenarios for
// latency, back-pressure, redirect and halt, then randomized traffic checked
// against a stream-level model (expected fetch order and decode order).
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        im_rd_en;
    logic [15:0] im_addr;
    logic [15:0] im_instr;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_bubble_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic        hlt_en   = 1'b0;
    logic [15:0] hlt_addr = 16'h0005;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .im_rd_en    (im_rd_en),
        .im_addr     (im_addr),
        .im_instr    (im_instr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .halted      (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: 16'h1000+addr, never a HLT unless at hlt_addr.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] w;
        w = a + 16'h1000;
        if (w[15:12] == 4'hF) w[15:12] = 4'h7;
        if (hlt_en && (a == hlt_addr)) w = 16'hF000;
        return w;
    endfunction

    function automatic logic is_hlt(input logic [15:0] w);
        return (w[15:12] == 4'hF);
    endfunction

    // Instruction memory: synchronous read, one cycle of latency.
    always @(posedge clk) begin
        if (im_rd_en) im_instr <= mem_word(im_addr);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        #1;
        chk("rst_rd_en", 32'(im_rd_en), 32'd0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_instr", 32'(id_instr), 32'd0);
        chk("rst_pc",    32'(id_pc),    32'd0);
        chk("rst_halt",  32'(halted),   32'd0);
`ifdef FETCH_PERF_EN
        chk("rst_bubble", 32'(perf_bubble_cnt), 32'd0);
        chk("rst_flush",  32'(perf_flush_cnt),  32'd0);
`endif
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int n_iss;
        int n_pop;
        logic [15:0] exp_pc;
        logic [15:0] exp_iss;
        logic pop_hlt;
        logic iss_hlt;

        rst_n = 1'b1;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        id_ready = 1'b0;
        im_instr = 16'h0000;

        // Streaming after reset: one issue per cycle, first valid two cycles later.
        id_ready = 1'b1;
        hlt_en = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            chk("t1_rd_en", 32'(im_rd_en), 32'd1);
            chk("t1_addr", 32'(im_addr), 32'(c));
            if (c < 2) begin
                chk("t1_valid_lo", 32'(id_valid), 32'd0);
            end else begin
                chk("t1_valid", 32'(id_valid), 32'd1);
                chk("t1_pc", 32'(id_pc), 32'(c - 2));
                chk("t1_instr", 32'(id_instr), 32'(mem_word(16'(c - 2))));
            end
        end

        // Back-pressure: exactly DEPTH reads, then drain in order without gaps.
        id_ready = 1'b0;
        do_reset();
        n_iss = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (im_rd_en) begin
                chk("t2_addr", 32'(im_addr), 32'(n_iss));
                n_iss++;
            end
            if (id_valid) chk("t2_head", 32'(id_pc), 32'd0);
        end
        chk("t2_reads", 32'(n_iss), 32'd4);
        chk("t2_rd_idle", 32'(im_rd_en), 32'd0);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            id_ready = 1'b1;
            #1;
            chk("t2_valid", 32'(id_valid), 32'd1);
            chk("t2_pc", 32'(id_pc), 32'(j));
        end

        // Redirect with three entries queued and one read outstanding.
        id_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 4; c++) @(negedge clk);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        chk("t3_head_before", 32'(id_pc), 32'd0);
        chk("t3_valid_redir", 32'(id_valid), 32'd0);
        chk("t3_rd_redir", 32'(im_rd_en), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        id_ready = 1'b1;
        #1;
        chk("t3_rd_en", 32'(im_rd_en), 32'd1);
        chk("t3_addr", 32'(im_addr), 32'h40);
        chk("t3_valid_gap", 32'(id_valid), 32'd0);
        @(negedge clk); #1;
        chk("t3_valid_gap2", 32'(id_valid), 32'd0);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk); #1;
            chk("t3_valid", 32'(id_valid), 32'd1);
            chk("t3_pc", 32'(id_pc), 32'(16'h0040 + 16'(j)));
        end

        // HLT at address 5: nothing past it fetched, PCs 0..5 delivered.
        hlt_en = 1'b1;
        hlt_addr = 16'h0005;
        id_ready = 1'b1;
        do_reset();
        n_iss = 0;
        n_pop = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk); #1;
            if (c == 6) chk("t4_halt_early", 32'(halted), 32'd0);
            if (c == 7) chk("t4_halt_set", 32'(halted), 32'd1);
            if (im_rd_en) begin
                chk("t4_addr", 32'(im_addr), 32'(n_iss));
                n_iss++;
            end
            if (id_valid & id_ready) begin
                chk("t4_pc", 32'(id_pc), 32'(n_pop));
                chk("t4_instr", 32'(id_instr), 32'(mem_word(16'(n_pop))));
                n_pop++;
            end
        end
        chk("t4_reads", 32'(n_iss), 32'd6);
        chk("t4_pops", 32'(n_pop), 32'd6);
        chk("t4_halted", 32'(halted), 32'd1);
        chk("t4_idle", 32'(id_valid), 32'd0);

        // Redirect out of HALTED to 16'hFFFF, PC wraps to 0.
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 16'hFFFF;
        #1;
        chk("t5_halt_hold", 32'(halted), 32'd1);
        chk("t5_rd_redir", 32'(im_rd_en), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("t5_unhalt", 32'(halted), 32'd0);
        chk("t5_rd_en", 32'(im_rd_en), 32'd1);
        chk("t5_addr0", 32'(im_addr), 32'hFFFF);
        @(negedge clk); #1;
        chk("t5_addr1", 32'(im_addr), 32'h0000);
        @(negedge clk); #1;
        chk("t5_pc0", 32'(id_pc), 32'hFFFF);
        chk("t5_instr0", 32'(id_instr), 32'(mem_word(16'hFFFF)));
        @(negedge clk); #1;
        chk("t5_pc1", 32'(id_pc), 32'h0000);
        chk("t5_instr1", 32'(id_instr), 32'h1000);

`ifdef FETCH_PERF_EN
        // Two redirects and their refill gaps counted as bubbles.
        hlt_en = 1'b0;
        id_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            redirect = ((c == 6) || (c == 12));
            redirect_pc = 16'h0020;
        end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("perf_flush", 32'(perf_flush_cnt), 32'd2);
        chk("perf_bubble", 32'(perf_bubble_cnt), 32'd8);
`endif

        // Randomized traffic against the fetch/decode stream model.
        for (int ph = 0; ph < 4; ph++) begin
            hlt_en = (ph != 0);
            hlt_addr = 16'($urandom_range(8, 48));
            id_ready = 1'b1;
            do_reset();
            exp_pc = 16'h0000;
            exp_iss = 16'h0000;
            pop_hlt = 1'b0;
            iss_hlt = 1'b0;
            n_pop = 0;
            for (int cyc = 0; cyc < 700; cyc++) begin
                @(negedge clk);
                redirect = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 3) == 0) redirect_pc = 16'hFFF8 + 16'($urandom_range(0, 7));
                else redirect_pc = 16'($urandom_range(0, 63));
                id_ready = ($urandom_range(0, 9) < 7);
                #1;
                if (redirect) begin
                    chk("r_valid_redir", 32'(id_valid), 32'd0);
                    chk("r_rd_redir", 32'(im_rd_en), 32'd0);
                    exp_pc = redirect_pc;
                    exp_iss = redirect_pc;
                    pop_hlt = 1'b0;
                    iss_hlt = 1'b0;
                end else begin
                    if (iss_hlt) begin
                        chk("r_issue_past_hlt", 32'(im_rd_en), 32'd0);
                    end else if (im_rd_en) begin
                        chk("r_addr", 32'(im_addr), 32'(exp_iss));
                        if (is_hlt(mem_word(exp_iss))) iss_hlt = 1'b1;
                        exp_iss = exp_iss + 16'd1;
                    end
                    if (pop_hlt) begin
                        chk("r_valid_after_hlt", 32'(id_valid), 32'd0);
                    end else if (id_valid & id_ready) begin
                        chk("r_pc", 32'(id_pc), 32'(exp_pc));
                        chk("r_instr", 32'(id_instr), 32'(mem_word(exp_pc)));
                        if (is_hlt(mem_word(exp_pc))) pop_hlt = 1'b1;
                        exp_pc = exp_pc + 16'd1;
                        n_pop++;
                    end
                end
            end
            chk("r_progress", 32'(n_pop > 100), 32'd1);
        end

        redirect = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
